// File: rtl/alu_share_if.sv
// rtl/alu_share_if.sv - request/response handshake bundle for the two ALU requesters
interface alu_share_if;
    logic        req_valid_0;
    logic        req_valid_1;
    logic        req_ready_0;
    logic        req_ready_1;
    logic [31:0] req_val1_0;
    logic [31:0] req_val1_1;
    logic [31:0] req_val2_0;
    logic [31:0] req_val2_1;
    logic [3:0]  req_cmd_0;
    logic [3:0]  req_cmd_1;
    logic        req_cin_0;
    logic        req_cin_1;
    logic        rsp_valid_0;
    logic        rsp_valid_1;
    logic        rsp_ready_0;
    logic        rsp_ready_1;
    logic [31:0] rsp_result_0;
    logic [31:0] rsp_result_1;
    logic [3:0]  rsp_status_0;
    logic [3:0]  rsp_status_1;

    modport master (
        output req_valid_0, req_valid_1, req_val1_0, req_val1_1, req_val2_0, req_val2_1,
        output req_cmd_0, req_cmd_1, req_cin_0, req_cin_1, rsp_ready_0, rsp_ready_1,
        input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
        input  rsp_result_0, rsp_result_1, rsp_status_0, rsp_status_1
    );

    modport slave (
        input  req_valid_0, req_valid_1, req_val1_0, req_val1_1, req_val2_0, req_val2_1,
        input  req_cmd_0, req_cmd_1, req_cin_0, req_cin_1, rsp_ready_0, rsp_ready_1,
        output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
        output rsp_result_0, rsp_result_1, rsp_status_0, rsp_status_1
    );
endinterface

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter sequencing two requesters onto one shared ALU
module alu_share_arb #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_share_if.slave  bus,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    output logic [3:0]  alu_cmd,
    output logic        alu_cin,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_status
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state;
    logic        prio;
    logic [31:0] op_val1;
    logic [31:0] op_val2;
    logic [3:0]  op_cmd;
    logic        op_cin;
    logic        op_owner;
    logic [31:0] res_q;
    logic [3:0]  stat_q;

    logic grant_0;
    logic grant_1;
    logic accept;
    logic op_legal;
    logic rsp_hs;
    logic in_exec;

    // MOV..MVN occupy codes 1..9; 0 and 10..15 are illegal
    assign op_legal = (op_cmd >= 4'd1) && (op_cmd <= 4'd9);

    assign grant_0 = bus.req_valid_0 && (!bus.req_valid_1 || (prio == 1'b0));
    assign grant_1 = bus.req_valid_1 && (!bus.req_valid_0 || (prio == 1'b1));
    assign accept  = (state == S_IDLE) && (grant_0 || grant_1);
    assign rsp_hs  = (state == S_RESP) && (op_owner ? bus.rsp_ready_1 : bus.rsp_ready_0);
    assign in_exec = (state == S_EXEC);

    assign bus.req_ready_0 = (state == S_IDLE) && grant_0;
    assign bus.req_ready_1 = (state == S_IDLE) && grant_1;

    assign bus.rsp_valid_0  = (state == S_RESP) && !op_owner;
    assign bus.rsp_valid_1  = (state == S_RESP) && op_owner;
    assign bus.rsp_result_0 = bus.rsp_valid_0 ? res_q  : 32'h0;
    assign bus.rsp_result_1 = bus.rsp_valid_1 ? res_q  : 32'h0;
    assign bus.rsp_status_0 = bus.rsp_valid_0 ? stat_q : 4'h0;
    assign bus.rsp_status_1 = bus.rsp_valid_1 ? stat_q : 4'h0;

    // ALU is parked at all-zero whenever no operation is executing
    assign alu_val1 = in_exec ? op_val1 : 32'h0;
    assign alu_val2 = in_exec ? op_val2 : 32'h0;
    assign alu_cmd  = (in_exec && op_legal) ? op_cmd : 4'h0;
    assign alu_cin  = in_exec && op_cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            prio     <= RR_INIT;
            op_val1  <= 32'h0;
            op_val2  <= 32'h0;
            op_cmd   <= 4'h0;
            op_cin   <= 1'b0;
            op_owner <= 1'b0;
            res_q    <= 32'h0;
            stat_q   <= 4'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_val1  <= grant_0 ? bus.req_val1_0 : bus.req_val1_1;
                        op_val2  <= grant_0 ? bus.req_val2_0 : bus.req_val2_1;
                        op_cmd   <= grant_0 ? bus.req_cmd_0  : bus.req_cmd_1;
                        op_cin   <= grant_0 ? bus.req_cin_0  : bus.req_cin_1;
                        op_owner <= !grant_0;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q  <= op_legal ? alu_result : 32'h0;
                    stat_q <= op_legal ? alu_status : 4'h0;
                    state  <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_hs) begin
                        prio  <= !op_owner;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed and randomized checks of alu_share_arb against a reference ALU model
module tb_alu_share_arb;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
        logic        ci;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [3:0]  alu_cmd;
    logic        alu_cin;
    logic [31:0] alu_result;
    logic [3:0]  alu_status;
    int          n_tests = 0;
    int          n_fail = 0;

    alu_share_if bus ();

    alu_share_arb #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cmd(alu_cmd), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_status(alu_status)
    );

    always #5 clk = ~clk;

    // reference: {N,Z,C,V, result}; illegal codes yield all zeros
    function automatic logic [35:0] ref_op(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic ci);
        logic [32:0] w;
        logic [31:0] r;
        logic        cf;
        logic        vf;
        w = 33'h0; r = 32'h0; cf = 1'b0; vf = 1'b0;
        case (c)
            4'd1: r = b;
            4'd9: r = ~b;
            4'd2: begin w = {1'b0, a} + {1'b0, b};          r = w[31:0]; cf = w[32]; vf = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd3: begin w = {1'b0, a} + {1'b0, b} + 33'(ci); r = w[31:0]; cf = w[32]; vf = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd4: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1;  r = w[31:0]; cf = w[32]; vf = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd5: begin w = {1'b0, a} + {1'b0, ~b} + 33'(ci); r = w[31:0]; cf = w[32]; vf = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd6: r = a & b;
            4'd7: r = a | b;
            4'd8: r = a ^ b;
            default: return 36'h0;
        endcase
        return {r[31], (r == 32'h0), cf, vf, r};
    endfunction

    // external ALU; a parked (0000) command produces junk that must never reach a requester
    always_comb begin
        alu_result = 32'hDEADBEEF;
        alu_status = 4'hF;
        if (alu_cmd != 4'h0) begin
            {alu_status, alu_result} = ref_op(alu_cmd, alu_val1, alu_val2, alu_cin);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input op_t o);
        if (p == 0) begin
            bus.req_valid_0 = v; bus.req_val1_0 = o.a; bus.req_val2_0 = o.b; bus.req_cmd_0 = o.c; bus.req_cin_0 = o.ci;
        end else begin
            bus.req_valid_1 = v; bus.req_val1_1 = o.a; bus.req_val2_1 = o.b; bus.req_cmd_1 = o.c; bus.req_cin_1 = o.ci;
        end
    endtask

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c, input logic ci);
        op_t o;
        o.a = a; o.b = b; o.c = c; o.ci = ci;
        return o;
    endfunction

    function automatic logic rdy(input int p);
        return (p == 0) ? bus.req_ready_0 : bus.req_ready_1;
    endfunction

    function automatic logic rvld(input int p);
        return (p == 0) ? bus.rsp_valid_0 : bus.rsp_valid_1;
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0;
        set_req(0, 1'b0, mk(0, 0, 0, 0));
        set_req(1, 1'b0, mk(0, 0, 0, 0));
        bus.rsp_ready_0 = 1'b1;
        bus.rsp_ready_1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // waits (bounded) for ready on port p, then lets the handshake edge pass and drops valid
    task automatic accept_wait(input int p, input string tag);
        int n = 0;
        @(negedge clk);
        while (!rdy(p) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(rdy(p)), 64'd1);
        tick();
        set_req(p, 1'b0, mk(0, 0, 0, 0));
    endtask

    task automatic rsp_wait(input int p, input logic [31:0] er, input logic [3:0] es, input string tag);
        int n = 0;
        @(negedge clk);
        while (!rvld(p) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 64'(rvld(p)), 64'd1);
        check({tag, "_result"}, 64'((p == 0) ? bus.rsp_result_0 : bus.rsp_result_1), 64'(er));
        check({tag, "_status"}, 64'((p == 0) ? bus.rsp_status_0 : bus.rsp_status_1), 64'(es));
        check({tag, "_other"}, 64'(rvld(1 - p)), 64'd0);
        tick();
    endtask

    op_t         ops[2][10];
    int          idx[2];
    logic        holding[2];
    logic        acc_flag[2];
    int          pend_port;
    logic [35:0] pend_exp;
    int          delivered;
    int          model_prio;
    int          winner;
    logic [31:0] held_res;

    initial begin
        reset_dut();
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_ready", 64'({bus.req_ready_0, bus.req_ready_1, bus.rsp_valid_0, bus.rsp_valid_1}), 64'd0);
        check("reset_rsp", 64'({bus.rsp_result_0, bus.rsp_result_1, bus.rsp_status_0, bus.rsp_status_1}), 64'd0);
        check("reset_alu", 64'({alu_val1, alu_cmd, alu_cin}) | 64'(alu_val2), 64'd0);
        reset_dut();

        // single ADD on port 0 with cycle-exact timing
        tick();
        set_req(0, 1'b1, mk(32'd5, 32'd7, 4'b0010, 1'b0));
        @(negedge clk);
        check("add_ready0", 64'(bus.req_ready_0), 64'd1);
        check("add_ready1", 64'(bus.req_ready_1), 64'd0);
        tick();
        set_req(0, 1'b0, mk(0, 0, 0, 0));
        @(negedge clk);
        check("add_exec_cmd", 64'(alu_cmd), 64'h2);
        check("add_exec_ops", {alu_val1, alu_val2}, {32'd5, 32'd7});
        check("add_exec_rspv", 64'(bus.rsp_valid_0), 64'd0);
        @(negedge clk);
        check("add_rsp_valid", 64'(bus.rsp_valid_0), 64'd1);
        check("add_rsp_res", 64'(bus.rsp_result_0), 64'd12);
        check("add_rsp_stat", 64'(bus.rsp_status_0), 64'h0);
        check("add_rsp_v1", 64'({bus.rsp_valid_1, bus.rsp_result_1}), 64'd0);
        check("add_alu_parked", 64'(alu_cmd), 64'h0);
        @(negedge clk);
        check("add_done", 64'(bus.rsp_valid_0), 64'd0);

        // simultaneous requests, RR_INIT=0
        reset_dut();
        tick();
        set_req(0, 1'b1, mk(32'd3, 32'd3, 4'b0100, 1'b0));
        set_req(1, 1'b1, mk(32'hFFFF0000, 32'h0000FFFF, 4'b1000, 1'b0));
        @(negedge clk);
        check("sim_only_one", 64'({bus.req_ready_0, bus.req_ready_1}), 64'b10);
        accept_wait(0, "sim_acc0");
        rsp_wait(0, 32'h0, 4'b0110, "sim_sub0");
        accept_wait(1, "sim_acc1");
        rsp_wait(1, 32'hFFFFFFFF, 4'b1000, "sim_eor1");
        set_req(0, 1'b1, mk(32'd1, 32'd2, 4'b0111, 1'b0));
        set_req(1, 1'b1, mk(32'd4, 32'd8, 4'b0111, 1'b0));
        @(negedge clk);
        check("sim_pair2", 64'({bus.req_ready_0, bus.req_ready_1}), 64'b10);
        accept_wait(0, "sim2_acc0");
        rsp_wait(0, 32'd3, 4'b0000, "sim2_orr0");
        accept_wait(1, "sim2_acc1");
        rsp_wait(1, 32'd12, 4'b0000, "sim2_orr1");

        // backpressure on port 1 while port 0 waits
        reset_dut();
        tick();
        bus.rsp_ready_1 = 1'b0;
        set_req(1, 1'b1, mk(32'h7FFFFFFF, 32'h0, 4'b0011, 1'b1));
        accept_wait(1, "bp_acc1");
        set_req(0, 1'b1, mk(32'd10, 32'd4, 4'b0100, 1'b0));
        @(negedge clk);
        @(negedge clk);
        check("bp_valid1", 64'(bus.rsp_valid_1), 64'd1);
        held_res = bus.rsp_result_1;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_res", 64'(bus.rsp_result_1), 64'h80000000);
            check("bp_hold_stat", 64'(bus.rsp_status_1), 64'b1001);
            check("bp_block0", 64'(bus.req_ready_0), 64'd0);
            @(negedge clk);
        end
        check("bp_stable", 64'(bus.rsp_result_1), 64'(held_res));
        #4 bus.rsp_ready_1 = 1'b1;
        @(negedge clk);
        check("bp_next_acc", 64'(bus.req_ready_0), 64'd1);
        tick();
        set_req(0, 1'b0, mk(0, 0, 0, 0));
        rsp_wait(0, 32'd6, 4'b0010, "bp_sub0");

        // illegal command never reaches the ALU
        tick();
        set_req(1, 1'b1, mk(32'h1234, 32'h5678, 4'b1111, 1'b1));
        accept_wait(1, "ill_acc");
        @(negedge clk);
        check("ill_alu_cmd", 64'(alu_cmd), 64'h0);
        rsp_wait(1, 32'h0, 4'h0, "ill_rsp");

        // asynchronous reset while a response is pending
        bus.rsp_ready_0 = 1'b0;
        set_req(0, 1'b1, mk(32'd9, 32'd9, 4'b0010, 1'b0));
        accept_wait(0, "rst_acc");
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_valid", 64'(bus.rsp_valid_0), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'({bus.rsp_valid_0, bus.rsp_valid_1, bus.req_ready_0, bus.req_ready_1}), 64'd0);
        check("rst_async_res", 64'({bus.rsp_result_0, bus.rsp_status_0}), 64'd0);
        bus.rsp_ready_0 = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_req(0, 1'b1, mk(32'd20, 32'd22, 4'b0010, 1'b0));
        accept_wait(0, "rst_fresh_acc");
        rsp_wait(0, 32'd42, 4'b0000, "rst_fresh");

        // randomized contention against the reference model
        reset_dut();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) begin
                ops[p][i] = mk($urandom, $urandom, ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(1, 9)), 1'($urandom));
            end
            idx[p] = 0; holding[p] = 1'b0; acc_flag[p] = 1'b0;
        end
        pend_port = -1; pend_exp = 36'h0; delivered = 0; model_prio = 0;
        for (int cyc = 0; cyc < 3000 && delivered < 20; cyc++) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (acc_flag[p]) begin
                    set_req(p, 1'b0, mk(0, 0, 0, 0));
                    idx[p]++; acc_flag[p] = 1'b0; holding[p] = 1'b0;
                end
                if (!holding[p] && idx[p] < 10 && $urandom_range(0, 3) != 0) begin
                    set_req(p, 1'b1, ops[p][idx[p]]);
                    holding[p] = 1'b1;
                end
            end
            bus.rsp_ready_0 = ($urandom_range(0, 3) != 0);
            bus.rsp_ready_1 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.req_ready_0 || bus.req_ready_1) begin
                winner = bus.req_ready_1 ? 1 : 0;
                check("rnd_one_ready", 64'(bus.req_ready_0 && bus.req_ready_1), 64'd0);
                check("rnd_idle", 64'(pend_port), 64'(-1));
                check("rnd_ready_has_valid", 64'(winner == 1 ? bus.req_valid_1 : bus.req_valid_0), 64'd1);
                if (bus.req_valid_0 && bus.req_valid_1) check("rnd_rr_grant", 64'(winner), 64'(model_prio));
                pend_port = winner;
                pend_exp  = ref_op(ops[winner][idx[winner]].c, ops[winner][idx[winner]].a,
                                   ops[winner][idx[winner]].b, ops[winner][idx[winner]].ci);
                acc_flag[winner] = 1'b1;
            end
            if (bus.rsp_valid_0 || bus.rsp_valid_1) begin
                winner = bus.rsp_valid_1 ? 1 : 0;
                check("rnd_rsp_owner", 64'(winner), 64'(pend_port));
                check("rnd_rsp_both", 64'(bus.rsp_valid_0 && bus.rsp_valid_1), 64'd0);
                check("rnd_rsp_data", 64'(winner == 1 ? {bus.rsp_status_1, bus.rsp_result_1} : {bus.rsp_status_0, bus.rsp_result_0}), 64'(pend_exp));
                check("rnd_rsp_other", 64'(winner == 1 ? {bus.rsp_status_0, bus.rsp_result_0} : {bus.rsp_status_1, bus.rsp_result_1}), 64'd0);
                if (winner == 1 ? bus.rsp_ready_1 : bus.rsp_ready_0) begin
                    delivered++;
                    model_prio = 1 - winner;
                    pend_port = -1;
                end
            end
        end
        check("rnd_delivered", 64'(delivered), 64'd20);
        check("rnd_issued", 64'(idx[0] + idx[1] + int'(acc_flag[0]) + int'(acc_flag[1])), 64'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
